// File: rtl/local_predictor_param_pkg.sv
// Shared types, default parameters and the BHT index helper for the local-history predictor.
package local_pred_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } pred_state_e;

  localparam int unsigned PC_W_DEF     = 32;
  localparam int unsigned IDX_W_DEF    = 6;
  localparam int unsigned HIST_W_DEF   = 4;
  localparam int unsigned CTR_W_DEF    = 2;
  localparam int unsigned CTR_INIT_DEF = 1;
  localparam int unsigned STAT_W       = 32;

  // Word-aligned PCs: drop the two byte-offset bits, keep idx_w bits above them.
  function automatic int unsigned bht_idx(input logic [63:0] pc, input int unsigned idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return 32'((pc >> 2) & mask);
  endfunction

endpackage

// File: rtl/local_predictor_param_if.sv
// Lookup/update/status bundle of the local predictor. Stats signals exist only with LOCAL_PRED_STATS_EN.
interface local_predictor_param_if #(
  parameter int unsigned PC_W = local_pred_pkg::PC_W_DEF
);

  logic [PC_W-1:0] pc_if;
  logic [PC_W-1:0] pc_ex;
  logic            update_en;
  logic            branch_outcome;
  logic            predict_taken;
  logic            predict_conf;
  logic            ready;
`ifdef LOCAL_PRED_STATS_EN
  logic                              predicted_ex;
  logic [local_pred_pkg::STAT_W-1:0] stat_updates;
  logic [local_pred_pkg::STAT_W-1:0] stat_mispredicts;

  modport master (
    output pc_if, pc_ex, update_en, branch_outcome, predicted_ex,
    input  predict_taken, predict_conf, ready, stat_updates, stat_mispredicts
  );

  modport slave (
    input  pc_if, pc_ex, update_en, branch_outcome, predicted_ex,
    output predict_taken, predict_conf, ready, stat_updates, stat_mispredicts
  );
`else
  modport master (
    output pc_if, pc_ex, update_en, branch_outcome,
    input  predict_taken, predict_conf, ready
  );

  modport slave (
    input  pc_if, pc_ex, update_en, branch_outcome,
    output predict_taken, predict_conf, ready
  );
`endif

endinterface

// File: rtl/local_predictor_param_sat_ctr_update.sv
// Saturating up/down counter step: +1 on taken, -1 on not-taken, clamped to [0, max].
module sat_ctr_update #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] i_ctr,
  input  logic             i_outcome,
  output logic [CTR_W-1:0] o_ctr_nxt
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  always_comb begin
    o_ctr_nxt = i_ctr;
    if (i_outcome) begin
      if (i_ctr != CTR_MAX) o_ctr_nxt = i_ctr + CTR_W'(1);
    end else begin
      if (i_ctr != '0) o_ctr_nxt = i_ctr - CTR_W'(1);
    end
  end

endmodule

// File: rtl/local_predictor_param.sv
// Two-level local-history branch predictor with table-clear sequencer after reset.
// Optional statistics counters are built when LOCAL_PRED_STATS_EN is defined.
module local_predictor_param
  import local_pred_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned IDX_W    = IDX_W_DEF,
  parameter int unsigned HIST_W   = HIST_W_DEF,
  parameter int unsigned CTR_W    = CTR_W_DEF,
  parameter int unsigned CTR_INIT = CTR_INIT_DEF
) (
  input logic                    clk,
  input logic                    rst,
  local_predictor_param_if.slave bus
);

  localparam int unsigned PTR_W = IDX_W + HIST_W;
  localparam int unsigned BHT_N = 2 ** IDX_W;
  localparam int unsigned PHT_N = 2 ** PTR_W;

  localparam logic [PTR_W-1:0] PTR_LAST = '1;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_RST  = CTR_W'(CTR_INIT);

  pred_state_e      r_state;
  logic [PTR_W-1:0] r_clr_ptr;
  logic             r_ready;

  logic [HIST_W-1:0] r_bht [BHT_N];
  logic [CTR_W-1:0]  r_pht [PHT_N];

  logic [PC_W-1:0]   w_pc_if;
  logic [PC_W-1:0]   w_pc_ex;
  logic [IDX_W-1:0]  w_idx_if;
  logic [IDX_W-1:0]  w_idx_ex;
  logic [HIST_W-1:0] w_hist_if;
  logic [HIST_W-1:0] w_hist_ex;
  logic [HIST_W-1:0] w_hist_ex_nxt;
  logic [CTR_W-1:0]  w_ctr_if;
  logic [CTR_W-1:0]  w_ctr_ex;
  logic [CTR_W-1:0]  w_ctr_ex_nxt;
  logic              w_upd_acc;

  assign w_pc_if  = bus.pc_if;
  assign w_pc_ex  = bus.pc_ex;
  assign w_idx_if = IDX_W'(bht_idx(64'(w_pc_if), IDX_W));
  assign w_idx_ex = IDX_W'(bht_idx(64'(w_pc_ex), IDX_W));

  // Lookup path reads table state only, so a same-cycle update is seen one cycle later.
  assign w_hist_if = r_bht[w_idx_if];
  assign w_ctr_if  = r_pht[{w_idx_if, w_hist_if}];

  assign bus.predict_taken = r_ready & w_ctr_if[CTR_W-1];
  assign bus.predict_conf  = r_ready & ((w_ctr_if == '0) | (w_ctr_if == CTR_MAX));
  assign bus.ready         = r_ready;

  assign w_upd_acc     = bus.update_en & (r_state == RUN);
  assign w_hist_ex     = r_bht[w_idx_ex];
  assign w_ctr_ex      = r_pht[{w_idx_ex, w_hist_ex}];
  // Truncating the concatenation keeps the youngest HIST_W outcomes, also for HIST_W == 1.
  assign w_hist_ex_nxt = HIST_W'({w_hist_ex, bus.branch_outcome});

  sat_ctr_update #(
    .CTR_W (CTR_W)
  ) u_sat_ctr (
    .i_ctr     (w_ctr_ex),
    .i_outcome (bus.branch_outcome),
    .o_ctr_nxt (w_ctr_ex_nxt)
  );

  // Init sequencer: sweep every PHT address once, then go live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= INIT;
      r_clr_ptr <= '0;
      r_ready   <= 1'b0;
    end else if (r_state == INIT) begin
      r_clr_ptr <= r_clr_ptr + PTR_W'(1);
      if (r_clr_ptr == PTR_LAST) begin
        r_state <= RUN;
        r_ready <= 1'b1;
      end
    end else begin
      r_ready <= 1'b1;
    end
  end

  // Table storage has no reset; contents are rebuilt by the init sweep.
  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_pht[r_clr_ptr] <= CTR_RST;
      if (r_clr_ptr[HIST_W-1:0] == '0) r_bht[r_clr_ptr[PTR_W-1:HIST_W]] <= '0;
    end else if (w_upd_acc) begin
      r_pht[{w_idx_ex, w_hist_ex}] <= w_ctr_ex_nxt;
      r_bht[w_idx_ex]              <= w_hist_ex_nxt;
    end
  end

`ifdef LOCAL_PRED_STATS_EN
  logic [STAT_W-1:0] r_stat_updates;
  logic [STAT_W-1:0] r_stat_mispredicts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_updates     <= '0;
      r_stat_mispredicts <= '0;
    end else if (w_upd_acc) begin
      r_stat_updates <= r_stat_updates + STAT_W'(1);
      if (bus.predicted_ex != bus.branch_outcome)
        r_stat_mispredicts <= r_stat_mispredicts + STAT_W'(1);
    end
  end

  assign bus.stat_updates     = r_stat_updates;
  assign bus.stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
